// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: framing nibbles, CRC-32 constants and TX state encoding.
package eth_pkg;

  localparam logic [3:0]  PRE_NIBBLE  = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE  = 4'hD;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value left after a frame plus its own FCS has been folded in.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

endpackage

// File: rtl/mii_mac_tx_if.sv
// Byte-stream handshake from the TX buffer into the MAC.
interface mii_mac_tx_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/eth_crc32_d4.sv
// Reflected CRC-32 register advanced by one nibble (LSB first) per enabled cycle.
module eth_crc32_d4
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [3:0]  d,
  output logic [31:0] crc
);

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] nib);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[0] ^ nib[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // CRC register: init has priority over a data update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc_step(crc, d);
  end

endmodule

// File: rtl/mii_mac_tx.sv
// MII transmit MAC: preamble/SFD, data nibbles, zero padding, FCS and inter-frame gap.
module mii_mac_tx
  import eth_pkg::*;
#(
  parameter int MIN_FRAME   = 60,
  parameter int IFG_NIBBLES = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  mii_mac_tx_if.slave src,
  output logic       phy_tx_en,
  output logic [3:0] phy_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       underflow
);

  localparam int CNT_W = (IFG_NIBBLES > 16) ? $clog2(IFG_NIBBLES) + 1 : 5;
  localparam logic [10:0]      MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);
  // With a zero gap the frame end goes straight back to IDLE.
  localparam tx_state_t AFTER_FRAME = (IFG_NIBBLES == 0) ? IDLE : IFG;

  tx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             hi, hi_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic [10:0]      bcnt, bcnt_d;
  logic             abort;
  logic             in_ready_q;
  logic             tx_en_d, ready_d, busy_d, done_d, uf_d;
  logic [3:0]       txd_d;
  logic [31:0]      crc;
  logic             crc_init, crc_en;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  assign src.in_ready = in_ready_q;

  // The CRC tracks the nibble about to go on the wire, so it is complete when FCS starts.
  assign crc_init = (state == IDLE);
  assign crc_en   = (state_d == DATA) || (state_d == PAD);

  eth_crc32_d4 u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .init (crc_init),
    .en   (crc_en),
    .d    (txd_d),
    .crc  (crc)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= 1'b0;
      last_q     <= 1'b0;
      bcnt       <= '0;
      phy_tx_en  <= 1'b0;
      phy_txd    <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      hi         <= hi_d;
      last_q     <= last_d;
      bcnt       <= bcnt_d;
      phy_tx_en  <= tx_en_d;
      phy_txd    <= txd_d;
      in_ready_q <= ready_d;
      busy       <= busy_d;
      frame_done <= done_d;
      underflow  <= uf_d;
    end
  end

  // Current frame byte; pure data, no reset needed.
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  // Next-state, nibble phase, byte loading and byte counting.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = hi;
    byte_d  = byte_q;
    last_d  = last_q;
    bcnt_d  = bcnt;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        cnt_d  = '0;
        hi_d   = 1'b0;
        bcnt_d = '0;
        if (src.in_valid) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (cnt != PRE_LAST) begin
          cnt_d = cnt + CNT_W'(1);
        end else if (src.in_valid) begin
          state_d = DATA;
          hi_d    = 1'b0;
          byte_d  = src.in_data;
          last_d  = src.in_last;
          bcnt_d  = sat_inc(bcnt);
        end else begin
          state_d = AFTER_FRAME;
          cnt_d   = '0;
          abort   = 1'b1;
        end
      end
      DATA: begin
        if (!hi) begin
          hi_d = 1'b1;
        end else if (!last_q) begin
          if (src.in_valid) begin
            hi_d   = 1'b0;
            byte_d = src.in_data;
            last_d = src.in_last;
            bcnt_d = sat_inc(bcnt);
          end else begin
            state_d = AFTER_FRAME;
            cnt_d   = '0;
            abort   = 1'b1;
          end
        end else if (bcnt < MIN_LEN) begin
          state_d = PAD;
          hi_d    = 1'b0;
          bcnt_d  = sat_inc(bcnt);
        end else begin
          state_d = FCS;
          cnt_d   = '0;
        end
      end
      PAD: begin
        if (!hi) begin
          hi_d = 1'b1;
        end else if (bcnt < MIN_LEN) begin
          hi_d   = 1'b0;
          bcnt_d = sat_inc(bcnt);
        end else begin
          state_d = FCS;
          cnt_d   = '0;
        end
      end
      FCS: begin
        if (cnt == FCS_LAST) begin
          state_d = AFTER_FRAME;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      IFG: begin
        if (cnt == IFG_LAST) state_d = IDLE;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the cycle being entered, registered alongside the state.
  always_comb begin
    tx_en_d = 1'b0;
    txd_d   = 4'h0;
    ready_d = 1'b0;
    busy_d  = (state_d != IDLE);
    done_d  = 1'b0;
    uf_d    = abort;
    case (state_d)
      PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = (cnt_d == PRE_LAST) ? SFD_NIBBLE : PRE_NIBBLE;
        ready_d = (cnt_d == PRE_LAST);
      end
      DATA: begin
        tx_en_d = 1'b1;
        txd_d   = hi_d ? byte_d[7:4] : byte_d[3:0];
        ready_d = hi_d && !last_d;
      end
      PAD: tx_en_d = 1'b1;
      FCS: begin
        tx_en_d = 1'b1;
        txd_d   = ~crc[{cnt_d[2:0], 2'b00} +: 4];
        done_d  = (cnt_d == FCS_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mii_mac_tx.sv
// Self-checking bench for mii_mac_tx: table frames, corner sequences and random frames.
module tb_mii_mac_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mii_mac_tx_if src ();
  mii_mac_tx_if s0 ();

  logic       tx_en, busy, done, uf;
  logic [3:0] txd;
  logic       tx_en0, busy0, done0, uf0;
  logic [3:0] txd0;

  mii_mac_tx #(.MIN_FRAME(60), .IFG_NIBBLES(24)) dut (
    .clk(clk), .rst_n(rst_n), .src(src), .phy_tx_en(tx_en), .phy_txd(txd),
    .busy(busy), .frame_done(done), .underflow(uf));

  mii_mac_tx #(.MIN_FRAME(0), .IFG_NIBBLES(24)) dut0 (
    .clk(clk), .rst_n(rst_n), .src(s0), .phy_tx_en(tx_en0), .phy_txd(txd0),
    .busy(busy0), .frame_done(done0), .underflow(uf0));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor of the default instance ----------------
  logic [3:0] cur[$];
  logic [3:0] nib_log[$];
  int len_log[$];
  int done_log[$];
  int frames_seen = 0, uf_cnt = 0, uf_bad = 0;
  int low_run = 0, gap_last = -1, ifg_run = 0, ifg_last = -1;
  int busy_low = 0, busy_gap_last = -1, done_cnt = 0, done_at = 0;
  bit prev_en = 0, ifg_on = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur.delete();
      prev_en  = 0;
      done_cnt = 0;
      ifg_on   = 0;
      low_run  = 0;
    end else begin
      if (uf) begin
        uf_cnt++;
        if (tx_en) uf_bad++;
      end
      if (tx_en) begin
        if (!prev_en && low_run > 0) gap_last = low_run;
        low_run = 0;
        cur.push_back(txd);
        if (done) begin
          done_cnt++;
          done_at = cur.size();
        end
      end else begin
        if (prev_en) begin
          foreach (cur[i]) nib_log.push_back(cur[i]);
          len_log.push_back(cur.size());
          done_log.push_back((done_cnt == 1 && done_at == cur.size()) ? 1 : 0);
          cur.delete();
          done_cnt = 0;
          frames_seen++;
          ifg_on  = 1;
          ifg_run = 0;
        end
        low_run++;
        if (ifg_on) begin
          if (busy) ifg_run++;
          else begin
            ifg_last = ifg_run;
            ifg_on   = 0;
          end
        end
      end
      if (!busy) busy_low++;
      else begin
        if (busy_low > 0) busy_gap_last = busy_low;
        busy_low = 0;
      end
      prev_en = tx_en;
    end
  end

  // ---------------- monitor of the MIN_FRAME=0 instance ----------------
  logic [3:0] q0[$];
  logic [3:0] q0_done[$];
  int f0_seen = 0, done0_at = -1;
  bit p0 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      p0 = 0;
    end else begin
      if (tx_en0) begin
        q0.push_back(txd0);
        if (done0) done0_at = q0.size();
      end else if (p0) begin
        q0_done = q0;
        q0.delete();
        f0_seen++;
      end
      p0 = tx_en0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] tx_bytes[$];
  logic [3:0] exp_nib[$];
  int exp_len[$];
  int exp_done[$];

  // Expected wire nibbles for tx_bytes; cut >= 0 models an abort after that many bytes.
  task automatic model_frame(input int minf, input int cut);
    logic [31:0] c;
    logic [7:0]  b;
    int n;
    for (int i = 0; i < 15; i++) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    if (cut >= 0) begin
      for (int i = 0; i < cut; i++) begin
        exp_nib.push_back(tx_bytes[i][3:0]);
        exp_nib.push_back(tx_bytes[i][7:4]);
      end
      exp_len.push_back(16 + 2 * cut);
      exp_done.push_back(0);
      return;
    end
    n = (tx_bytes.size() < minf) ? minf : tx_bytes.size();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = (i < tx_bytes.size()) ? tx_bytes[i] : 8'h00;
      exp_nib.push_back(b[3:0]);
      exp_nib.push_back(b[7:4]);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 8; k++) exp_nib.push_back(c[4*k +: 4]);
    exp_len.push_back(16 + 2 * n + 8);
    exp_done.push_back(1);
  endtask

  task automatic compare_logs(input string tag);
    int bad = 0;
    check({tag, "_frames"}, len_log.size(), exp_len.size());
    for (int i = 0; i < exp_len.size() && i < len_log.size(); i++) begin
      check({tag, "_len"}, len_log[i], exp_len[i]);
      check({tag, "_done"}, done_log[i], exp_done[i]);
    end
    for (int i = 0; i < exp_nib.size(); i++)
      if (i >= nib_log.size() || nib_log[i] !== exp_nib[i]) bad++;
    check({tag, "_nibbles"}, bad, 0);
    nib_log.delete(); len_log.delete(); done_log.delete();
    exp_nib.delete(); exp_len.delete(); exp_done.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!src.in_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    ok = src.in_ready;
    if (!ok) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int drop_at);
    bit ok;
    for (int i = 0; i < tx_bytes.size(); i++) begin
      if (i == drop_at) begin
        src.in_valid = 1'b0;
        src.in_last  = 1'b0;
        return;
      end
      src.in_data  = tx_bytes[i];
      src.in_valid = 1'b1;
      src.in_last  = (i == tx_bytes.size() - 1);
      wait_ready(ok);
      if (!ok) begin
        src.in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames_seen < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("frame_count", frames_seen, target);
  endtask

  task automatic fill(input int len, input logic [7:0] base);
    tx_bytes.delete();
    for (int j = 0; j < len; j++) tx_bytes.push_back(8'(base + j));
  endtask

  task automatic run_frame(input int len, input logic [7:0] base, input int cyc, input string tag);
    int target;
    fill(len, base);
    model_frame(60, -1);
    target = frames_seen + 1;
    send_frame(-1);
    src.in_valid = 1'b0;
    wait_frames(target);
    if (len_log.size() > 0) check({tag, "_txen_cycles"}, len_log[len_log.size()-1], cyc);
    compare_logs(tag);
    idle(30);
  endtask

  typedef struct {
    int         len;
    logic [7:0] base;
    int         cyc;
  } vec_t;

  vec_t tbl[6];
  logic [3:0] fcs_exp[8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, uf_before, t, len;
    bit dummy;
    tbl[0] = '{60,  8'h00, 144};
    tbl[1] = '{1,   8'hAB, 144};
    tbl[2] = '{64,  8'h10, 152};
    tbl[3] = '{59,  8'h40, 144};
    tbl[4] = '{61,  8'h7F, 146};
    tbl[5] = '{130, 8'hC0, 284};

    src.in_data = 8'h00; src.in_valid = 1'b0; src.in_last = 1'b0;
    s0.in_data  = 8'h00; s0.in_valid  = 1'b0; s0.in_last  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_tx_en", tx_en, 0);
    check("rst_txd", txd, 0);
    check("rst_ready", src.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underflow", uf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) run_frame(tbl[i].len, tbl[i].base, tbl[i].cyc, "table");

    // "123456789" with padding disabled: spec-given FCS nibbles.
    for (int i = 0; i < 9; i++) begin
      s0.in_data  = 8'(8'h31 + i);
      s0.in_valid = 1'b1;
      s0.in_last  = (i == 8);
      t = 0;
      @(negedge clk);
      while (!s0.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk);
      #1;
    end
    s0.in_valid = 1'b0;
    t = 0;
    while (f0_seen < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("crc9_frames", f0_seen, 1);
    check("crc9_len", q0_done.size(), 42);
    check("crc9_done_pos", done0_at, 42);
    if (q0_done.size() >= 8)
      for (int k = 0; k < 8; k++) check("crc9_fcs", q0_done[q0_done.size()-8+k], fcs_exp[k]);
    idle(30);

    // Two 64-byte frames queued back to back.
    target = frames_seen + 2;
    fill(64, 8'h00); model_frame(60, -1); send_frame(-1);
    fill(64, 8'h80); model_frame(60, -1); send_frame(-1);
    src.in_valid = 1'b0;
    wait_frames(target);
    idle(30);
    check("b2b_gap", gap_last, 25);
    check("b2b_busy_low", busy_gap_last, 1);
    compare_logs("b2b");

    // Source stalls after 10 bytes of a 64-byte frame.
    uf_before = uf_cnt;
    target = frames_seen + 1;
    fill(64, 8'h20);
    model_frame(60, 10);
    send_frame(10);
    wait_frames(target);
    idle(40);
    check("uf_pulses", uf_cnt - uf_before, 1);
    check("uf_while_tx_en", uf_bad, 0);
    check("uf_ifg", ifg_last, 24);
    compare_logs("underflow");
    run_frame(64, 8'h55, 152, "after_uf");
    check("ifg_normal", ifg_last, 24);

    // Reset during FCS, then a clean frame with start-latency check.
    fill(64, 8'h33);
    send_frame(-1);
    src.in_valid = 1'b0;
    t = 0;
    while (cur.size() < 147 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("reach_fcs", cur.size() >= 147, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_en", tx_en, 0);
    check("mid_rst_txd", txd, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", src.in_ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_underflow", uf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    fill(64, 8'h90);
    model_frame(60, -1);
    target = frames_seen + 1;
    @(posedge clk);
    #1;
    src.in_data = tx_bytes[0]; src.in_valid = 1'b1; src.in_last = 1'b0;
    @(negedge clk);
    check("start_latency_pre", tx_en, 0);
    @(negedge clk);
    check("start_latency_en", tx_en, 1);
    check("start_latency_txd", txd, 5);
    send_frame(-1);
    src.in_valid = 1'b0;
    wait_frames(target);
    compare_logs("post_rst");
    idle(30);

    // Random frames with random idle spacing (sometimes back to back).
    target = frames_seen + 10;
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(1, 90);
      tx_bytes.delete();
      for (int j = 0; j < len; j++) tx_bytes.push_back(8'($urandom));
      model_frame(60, -1);
      send_frame(-1);
      if ($urandom_range(0, 2) != 0) begin
        src.in_valid = 1'b0;
        idle($urandom_range(0, 20));
      end
    end
    src.in_valid = 1'b0;
    wait_frames(target);
    idle(30);
    compare_logs("random");
    check("random_ifg", ifg_last, 24);
    dummy = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mii_mac_tx.md
# mii_mac_tx

MII transmit MAC: pulls bytes of one Ethernet frame from the TX buffer and drives the PHY transmit nibble interface. It inserts the preamble and SFD, pads short frames, appends the IEEE 802.3 CRC-32 FCS and enforces the inter-frame gap. It is the transmit-side counterpart of the MII receive path into the RX FIFO and drives `phy_tx_en`/`phy_txd` at the top level.

## Interface
- `MIN_FRAME`, 60: minimum bytes before FCS; shorter frames are zero-padded to this length. 0 disables padding.
- `IFG_NIBBLES`, 24: `clk` cycles with `phy_tx_en` low after each frame (12 byte times).
- `clk`  in  1  single clock, driven from `phy_tx_clk` at top level; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  frame byte from TX buffer (destination address first).
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  qualifies the final byte of the frame.
- `in_ready`  out  1  byte consumed this cycle when `in_valid && in_ready`.
- `phy_tx_en`  out  1  MII transmit enable.
- `phy_txd`  out  4  MII transmit nibble.
- `busy`  out  1  high from frame start until end of IFG.
- `frame_done`  out  1  one-cycle pulse on the last FCS nibble.
- `underflow`  out  1  one-cycle pulse on frame abort.

## Operation
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
- IDLE: `in_ready`=0. When `in_valid`=1, go to PREAMBLE. The byte is not consumed yet.
- PREAMBLE: 16 nibbles: fifteen 0x5, then 0xD (SFD). On the SFD cycle, `in_ready`=1 to load the first byte.
- DATA: each byte is sent low nibble first, then high nibble. `in_ready`=1 on every high-nibble cycle unless the current byte had `in_last`.
- Last byte sent: if byte count < `MIN_FRAME`, go to PAD; else go to FCS.
- PAD: send 0x00 bytes, 2 nibbles each, until count = `MIN_FRAME`.
- CRC-32: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF. It covers all DATA and PAD nibbles.
- FCS: transmit the complement of the CRC, nibble [3:0] first through [31:28]; 8 cycles. Pulse `frame_done` on the 8th.
- IFG: `phy_tx_en`=0 and `phy_txd`=0 for `IFG_NIBBLES` cycles, then IDLE.
- Underflow: `in_ready`=1 with `in_valid`=0 in DATA.
  - Next cycle, `phy_tx_en`=0 (truncated frame, no FCS) and `underflow` pulses.
  - Go to IFG.
  - The remainder of the source frame is the upstream's problem; the block does not drain it.
- Byte counter is 11 bits and saturates at 2047; no maximum-length check.
- `in_last` is ignored outside accepted cycles.

## Timing
- All outputs are registered.
- Reset values: `phy_tx_en`=0, `phy_txd`=0, `in_ready`=0, `busy`=0, `frame_done`=0, `underflow`=0. State is IDLE and the CRC register is 0xFFFFFFFF.
- Reset asserted mid-frame: outputs are forced to reset values immediately (asynchronously); no IFG follows.
- `in_valid` sampled high in IDLE → `phy_tx_en` rises on the next edge with `phy_txd`=0x5.
- `phy_tx_en` is high for exactly 16 + 2·max(N, `MIN_FRAME`) + 8 consecutive cycles for an N-byte frame.
- Back-to-back frames: gap between `phy_tx_en` falling and rising is exactly `IFG_NIBBLES` cycles, plus 1 for the IDLE sample.
- `in_ready` is high at most every other cycle in DATA. Data lands in the byte register on the edge after acceptance.
- `busy` rises with `phy_tx_en` and falls on the edge that enters IDLE.

## Structure
- Shared package `eth_pkg`:
  - preamble nibble 0x5, SFD nibble 0xD;
  - CRC polynomial 0xEDB88320, CRC initial value 0xFFFFFFFF, CRC residue;
  - TX state enum.
- Sub-module `eth_crc32_d4`: 4-bit-per-cycle CRC-32 update with ports `clk`, `rst_n`, `init`, `en`, `d[3:0]`, `crc[31:0]`. It will be reused by the RX FCS checker.

## Test plan
- 60-byte frame, bytes 0x00..0x3B, back-pressure-free source → checks:
  - `phy_tx_en` high 144 cycles;
  - first 16 nibbles are 0x5 ×15 then 0xD;
  - next nibbles 0,0,1,0,2,0,…;
  - FCS matches the software CRC model.
- `MIN_FRAME`=0, ASCII "123456789" (0x31..0x39) → last 8 nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926 sent complemented-reflected per 802.3 model check); `frame_done` on the final one.
- 1-byte frame 0xAB → nibbles B,A, then 59 pad bytes of 0; `phy_tx_en` high 144 cycles; FCS correct.
- Two 64-byte frames queued continuously → exactly 25 cycles of `phy_tx_en`=0 between them; `busy` low for 1 cycle.
- `in_valid` dropped after byte 10 of a 64-byte frame → `phy_tx_en` falls next cycle; `underflow` pulses once; 24-cycle IFG; next frame transmits correctly.
- `rst_n` pulsed low during FCS → all outputs 0 immediately; the following frame starts with a full preamble and correct FCS.
